// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard host command sequencer.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    // Bit positions inside led_state and the 0xED mask byte.
    localparam int LED_CAPS   = 2;
    localparam int LED_NUM    = 1;
    localparam int LED_SCROLL = 0;

    localparam int TMR_W = 32;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_TX,
        ST_WAIT_RSP,
        ST_WAIT_BAT,
        ST_IDLE,
        ST_FAIL
    } state_t;

    // Which byte is in flight, so an ACK knows what comes next.
    typedef enum logic [2:0] {
        PH_RESET,
        PH_LED_CMD,
        PH_LED_MASK,
        PH_TYPE_CMD,
        PH_TYPE_ARG
    } phase_t;

endpackage

// File: rtl/ps2_kbd_host_ctrl_if.sv
// Command/receive port bundle shared between PS2_Controller and its host-side clients.
interface ps2_kbd_host_ctrl_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       send_command;
    logic [7:0] the_command;

    modport master (
        output send_command, the_command,
        input  received_data, received_data_en,
        input  command_was_sent, error_communication_timed_out
    );

    modport slave (
        input  send_command, the_command,
        output received_data, received_data_en,
        output command_was_sent, error_communication_timed_out
    );
endinterface

// File: rtl/ps2_timeout_ctr.sv
// Loadable down-counter; expired is high while armed and the count has reached zero.
module ps2_timeout_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] load_val,
    output logic         running,
    output logic         expired
);
    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            cnt     <= load_val;
            running <= 1'b1;
        end else if (clr) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (running && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = running && (cnt == '0);
endmodule

// File: rtl/ps2_kbd_host_ctrl.sv
// PS/2 keyboard host sequencer: reset/BAT init, LED sync, resend/timeout retry.
// Optional typematic setup after BAT is enabled with `define PS2_TYPEMATIC_EN.
module ps2_kbd_host_ctrl
    import ps2_pkg::*;
#(
    parameter int STARTUP_CYCLES = 5_000_000,
    parameter int ACK_TIMEOUT    = 1_000_000,
    parameter int BAT_TIMEOUT    = 50_000_000,
    parameter int MAX_RETRY      = 3
`ifdef PS2_TYPEMATIC_EN
    ,
    parameter logic [7:0] TYPEMATIC_BYTE = 8'h20
`endif
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    ps2_kbd_host_ctrl_if.master        ps2,
    input  logic                       caps_toggle,
    input  logic                       num_toggle,
    input  logic                       scroll_toggle,
    output logic [2:0]                 led_state,
    output logic                       busy,
    output logic                       init_done,
    output logic                       error
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 2);

    state_t               state, state_d;
    phase_t               phase, phase_d;
    logic [7:0]           cmd_byte, cmd_d;
    logic [RETRY_W-1:0]   retry, retry_d;
    logic                 pend, pend_d;
    logic [2:0]           led_d;
    logic                 init_d, err_d;
    logic                 fail_attempt;
    logic                 tmr_load, tmr_clr, tmr_run, tmr_exp;
    logic [TMR_W-1:0]     tmr_val;
    logic [2:0]           tog;

    assign tog = {caps_toggle, num_toggle, scroll_toggle};

    ps2_timeout_ctr #(.W(TMR_W)) u_tmr (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (tmr_load),
        .clr      (tmr_clr),
        .load_val (tmr_val),
        .running  (tmr_run),
        .expired  (tmr_exp)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_STARTUP;
            phase     <= PH_RESET;
            cmd_byte  <= 8'h00;
            retry     <= '0;
            pend      <= 1'b0;
            led_state <= 3'b000;
            init_done <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            cmd_byte  <= cmd_d;
            retry     <= retry_d;
            pend      <= pend_d;
            led_state <= led_d;
            init_done <= init_d;
            error     <= err_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        cmd_d        = cmd_byte;
        retry_d      = retry;
        pend_d       = pend;
        led_d        = led_state;
        init_d       = init_done;
        err_d        = error;
        fail_attempt = 1'b0;
        tmr_load     = 1'b0;
        tmr_clr      = 1'b0;
        tmr_val      = '0;

        if (state != ST_FAIL && state != ST_STARTUP && tog != 3'b000) begin
            led_d  = led_state ^ tog;
            pend_d = 1'b1;
        end

        case (state)
            ST_STARTUP: begin
                if (!tmr_run) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(STARTUP_CYCLES - 1);
                end else if (tmr_exp) begin
                    cmd_d   = CMD_RESET;
                    phase_d = PH_RESET;
                    state_d = ST_TX;
                end
            end
            ST_TX: begin
                tmr_clr = 1'b1;
                if (ps2.command_was_sent) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ACK_TIMEOUT - 1);
                    state_d  = ST_WAIT_RSP;
                end else if (ps2.error_communication_timed_out) begin
                    fail_attempt = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (ps2.received_data_en) begin
                    if (ps2.received_data == RSP_ACK) begin
                        retry_d = '0;
                        case (phase)
                            PH_RESET: begin
                                tmr_load = 1'b1;
                                tmr_val  = TMR_W'(BAT_TIMEOUT - 1);
                                state_d  = ST_WAIT_BAT;
                            end
                            PH_LED_CMD: begin
                                cmd_d   = {5'b0, led_state};
                                phase_d = PH_LED_MASK;
                                state_d = ST_TX;
                            end
`ifdef PS2_TYPEMATIC_EN
                            PH_TYPE_CMD: begin
                                cmd_d   = TYPEMATIC_BYTE;
                                phase_d = PH_TYPE_ARG;
                                state_d = ST_TX;
                            end
                            PH_TYPE_ARG: begin
                                init_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
`endif
                            default: state_d = ST_IDLE;
                        endcase
                    end else if (ps2.received_data == RSP_RESEND) begin
                        fail_attempt = 1'b1;
                    end
                end else if (tmr_exp) begin
                    fail_attempt = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (ps2.received_data_en && ps2.received_data == RSP_BAT_OK) begin
`ifdef PS2_TYPEMATIC_EN
                    cmd_d   = CMD_TYPEMATIC;
                    phase_d = PH_TYPE_CMD;
                    state_d = ST_TX;
`else
                    init_d  = 1'b1;
                    state_d = ST_IDLE;
`endif
                    if (led_state != 3'b000) pend_d = 1'b1;
                end else if ((ps2.received_data_en && ps2.received_data == RSP_BAT_FAIL) || tmr_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_FAIL;
                end
            end
            ST_IDLE: begin
                if (pend) begin
                    // A toggle landing in this very cycle must still schedule another sequence.
                    pend_d  = (tog != 3'b000);
                    cmd_d   = CMD_SET_LED;
                    phase_d = PH_LED_CMD;
                    state_d = ST_TX;
                end
            end
            ST_FAIL: ;
            default: state_d = ST_FAIL;
        endcase

        if (fail_attempt) begin
            if (retry < RETRY_W'(MAX_RETRY)) begin
                retry_d = retry + 1'b1;
                state_d = ST_TX;
            end else begin
                err_d   = 1'b1;
                state_d = ST_FAIL;
            end
        end
    end

    assign ps2.send_command = (state == ST_TX);
    assign ps2.the_command  = cmd_byte;
    assign busy             = (state != ST_IDLE) && (state != ST_FAIL);
endmodule

// File: tb/tb_ps2_kbd_host_ctrl.sv
// Directed self-checking bench for ps2_kbd_host_ctrl with a hand-driven PS2_Controller model.
module tb_ps2_kbd_host_ctrl;
    localparam int STARTUP_CYCLES = 10;
    localparam int ACK_TIMEOUT    = 20;
    localparam int BAT_TIMEOUT    = 200;
    localparam int MAX_RETRY      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       caps_toggle, num_toggle, scroll_toggle;
    logic [2:0] led_state;
    logic       busy, init_done, error;
    int         checks   = 0;
    int         failures = 0;

    ps2_kbd_host_ctrl_if ps2 ();

    ps2_kbd_host_ctrl #(
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .ACK_TIMEOUT    (ACK_TIMEOUT),
        .BAT_TIMEOUT    (BAT_TIMEOUT),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .ps2           (ps2),
        .caps_toggle   (caps_toggle),
        .num_toggle    (num_toggle),
        .scroll_toggle (scroll_toggle),
        .led_state     (led_state),
        .busy          (busy),
        .init_done     (init_done),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for send_command, captures the byte, then acknowledges transmission for one cycle.
    task automatic wait_send(input int budget, output logic [7:0] b, output logic ok, output int waited);
        ok = 1'b0;
        b = 8'hxx;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (ps2.send_command) begin
                ok = 1'b1;
                b = ps2.the_command;
                break;
            end
        end
        if (ok) begin
            ps2.command_was_sent = 1'b1;
            @(negedge clk);
            ps2.command_was_sent = 1'b0;
        end
    endtask

    task automatic expect_send(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        logic ok;
        int w;
        wait_send(80, b, ok, w);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_byte"}, 32'(b), 32'(exp));
        check({tag, "_drop"}, 32'(ps2.send_command), 32'd0);
    endtask

    task automatic reply(input logic [7:0] b);
        ps2.received_data = b;
        ps2.received_data_en = 1'b1;
        @(negedge clk);
        ps2.received_data_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] t);
        {caps_toggle, num_toggle, scroll_toggle} = t;
        @(negedge clk);
        {caps_toggle, num_toggle, scroll_toggle} = 3'b000;
    endtask

    task automatic count_sends(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ps2.send_command) cnt++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_send", 32'(ps2.send_command), 32'd0);
        check("rst_cmd", 32'(ps2.the_command), 32'h00);
        check("rst_led", 32'(led_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init", 32'(init_done), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        rst = 1'b0;
    endtask

    task automatic finish_init(input string tag);
        reply(8'hFA);
        check({tag, "_bat_busy"}, 32'(busy), 32'd1);
        check({tag, "_bat_init"}, 32'(init_done), 32'd0);
        reply(8'hAA);
`ifdef PS2_TYPEMATIC_EN
        expect_send({tag, "_tm_cmd"}, 8'hF3);
        reply(8'hFA);
        expect_send({tag, "_tm_arg"}, 8'h20);
        reply(8'hFA);
`endif
        check({tag, "_init"}, 32'(init_done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic ok;
        int w, n;

        rst = 1'b1;
        caps_toggle = 1'b0;
        num_toggle = 1'b0;
        scroll_toggle = 1'b0;
        ps2.received_data = 8'h00;
        ps2.received_data_en = 1'b0;
        ps2.command_was_sent = 1'b0;
        ps2.error_communication_timed_out = 1'b0;

        // Power-up: one 0xFF after the startup wait, then ACK + BAT.
        apply_reset();
        wait_send(60, b, ok, w);
        check("init_seen", 32'(ok), 32'd1);
        check("init_byte", 32'(b), 32'hFF);
        check("init_latency_ok", 32'(w >= STARTUP_CYCLES && w <= STARTUP_CYCLES + 2), 32'd1);
        check("init_drop", 32'(ps2.send_command), 32'd0);
        finish_init("init");
        check("init_led", 32'(led_state), 32'd0);
        count_sends(20, n);
        check("init_quiet", 32'(n), 32'd0);

        // Caps toggle in IDLE: 0xED then 0x04.
        pulse(3'b100);
        check("caps_led", 32'(led_state), 32'b100);
        expect_send("caps_ed", 8'hED);
        check("caps_busy1", 32'(busy), 32'd1);
        reply(8'hFA);
        expect_send("caps_mask", 8'h04);
        check("caps_busy2", 32'(busy), 32'd1);
        reply(8'hFA);
        check("caps_idle", 32'(busy), 32'd0);

        // Resend on 0xFE: 0xED repeated, then mask for caps off.
        pulse(3'b100);
        check("rs_led", 32'(led_state), 32'b000);
        expect_send("rs_ed1", 8'hED);
        reply(8'hFE);
        expect_send("rs_ed2", 8'hED);
        reply(8'hFA);
        expect_send("rs_mask", 8'h00);
        reply(8'hFA);
        check("rs_err", 32'(error), 32'd0);
        check("rs_idle", 32'(busy), 32'd0);

        // Num+scroll in one cycle while the caps mask is in flight coalesce into one more sequence.
        pulse(3'b100);
        expect_send("co_ed1", 8'hED);
        reply(8'hFA);
        expect_send("co_mask1", 8'h04);
        pulse(3'b011);
        check("co_led", 32'(led_state), 32'b111);
        reply(8'hFA);
        expect_send("co_ed2", 8'hED);
        reply(8'hFA);
        expect_send("co_mask2", 8'h07);
        reply(8'hFA);
        count_sends(40, n);
        check("co_quiet", 32'(n), 32'd0);
        check("co_idle", 32'(busy), 32'd0);

        // Reset while send_command is high clears it without a clock edge; init reruns.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ps2.send_command) begin
                ok = 1'b1;
                break;
            end
        end
        check("ar_send_hi", 32'(ok), 32'd1);
        #2 rst = 1'b1;
        #1 check("ar_send_lo", 32'(ps2.send_command), 32'd0);
        check("ar_led", 32'(led_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_send("ar_ff", 8'hFF);
        finish_init("ar");

        // No response at all: original + MAX_RETRY resends of 0xFF, then sticky error.
        apply_reset();
        for (int k = 0; k < MAX_RETRY + 1; k++) begin
            expect_send($sformatf("to_ff%0d", k), 8'hFF);
        end
        check("to_err_before", 32'(error), 32'd0);
        repeat (ACK_TIMEOUT + 5) @(negedge clk);
        check("to_err", 32'(error), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        count_sends(60, n);
        check("to_quiet", 32'(n), 32'd0);
        pulse(3'b100);
        check("to_led_frozen", 32'(led_state), 32'd0);

        // BAT failure byte.
        apply_reset();
        expect_send("bf_ff", 8'hFF);
        reply(8'hFA);
        reply(8'hFC);
        check("bf_err", 32'(error), 32'd1);
        check("bf_init", 32'(init_done), 32'd0);
        check("bf_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
